fetch_unit: RTL and testbench

//   Upstream instruction-fetch stage for compute_core. Accepts per-thread fetch requests (thread PC),

---
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: round-robin arbitration over per-thread fetch requests,
// one outstanding valid/ready read to program memory, per-thread result registers.
module fetch_unit #(
    parameter int NUM_THREADS = 4,
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_THREADS-1:0]             fetch_req,
    input  logic [NUM_THREADS*PC_WIDTH-1:0]    fetch_pc,
    output logic [NUM_THREADS-1:0]             fetch_done,
    output logic [NUM_THREADS*INSTR_WIDTH-1:0] fetch_instr,
    output logic                               mem_read_valid,
    output logic [PC_WIDTH-1:0]                mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [INSTR_WIDTH-1:0]             mem_read_data,
    output logic                               busy,
    output logic [CNT_WIDTH-1:0]               fetch_count
);

    localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                           state, state_next;
    logic [TID_W-1:0]                 rr_ptr, rr_ptr_next;
    logic [TID_W-1:0]                 tid, tid_next;
    logic [NUM_THREADS-1:0]           done_next;
    logic [NUM_THREADS*INSTR_WIDTH-1:0] instr_next;
    logic                             valid_next;
    logic [PC_WIDTH-1:0]              addr_next;
    logic [CNT_WIDTH-1:0]             count_next;

    logic                             grant_found;
    logic [TID_W-1:0]                 grant_tid;
    logic [TID_W-1:0]                 scan_idx;

    // Scan starts at rr_ptr, so the thread served last is visited last.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        grant_found = 1'b0;
        grant_tid   = '0;
        scan_idx    = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            scan_idx = TID_W'((int'(rr_ptr) + i) % NUM_THREADS);
            if (!grant_found && fetch_req[scan_idx]) begin
                grant_found = 1'b1;
                grant_tid   = scan_idx;
            end
        end
    end

    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        tid_next    = tid;
        done_next   = '0;
        instr_next  = fetch_instr;
        valid_next  = mem_read_valid;
        addr_next   = mem_read_address;
        count_next  = fetch_count;

        unique case (state)
            IDLE: begin
                if (grant_found) begin
                    tid_next   = grant_tid;
                    addr_next  = fetch_pc[int'(grant_tid)*PC_WIDTH +: PC_WIDTH];
                    valid_next = 1'b1;
                    state_next = REQUEST;
                end
            end
            REQUEST: begin
                // Address was latched at grant; later fetch_pc changes cannot disturb it.
                if (mem_read_ready) begin
                    instr_next[int'(tid)*INSTR_WIDTH +: INSTR_WIDTH] = mem_read_data;
                    valid_next      = 1'b0;
                    done_next[tid]  = 1'b1;
                    count_next      = fetch_count + CNT_WIDTH'(1);
                    rr_ptr_next     = TID_W'((int'(tid) + 1) % NUM_THREADS);
                    state_next      = RESPOND;
                end
            end
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            tid              <= '0;
            fetch_done       <= '0;
            fetch_instr      <= '0;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            fetch_count      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state            <= state_next;
            rr_ptr           <= rr_ptr_next;
            tid              <= tid_next;
            fetch_done       <= done_next;
            fetch_instr      <= instr_next;
            mem_read_valid   <= valid_next;
            mem_read_address <= addr_next;
            fetch_count      <= count_next;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, single fetch, round-robin, wait states,
// fairness after skip and counter wrap (DUT built with a 4-bit fetch counter).
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  fetch_req;
    logic [31:0] fetch_pc;
    logic [3:0]  fetch_done;
    logic [63:0] fetch_instr;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic        busy;
    logic [3:0]  fetch_count;

    logic        use_fixed;
    logic [15:0] fixed_data;

    int          checks = 0;
    int          errors = 0;
    int          exp_count;
    logic [15:0] exp_instr [4];

    fetch_unit #(
        .NUM_THREADS(4),
        .PC_WIDTH   (8),
        .INSTR_WIDTH(16),
        .CNT_WIDTH  (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_req       (fetch_req),
        .fetch_pc        (fetch_pc),
        .fetch_done      (fetch_done),
        .fetch_instr     (fetch_instr),
        .mem_read_valid  (mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready  (mem_read_ready),
        .mem_read_data   (mem_read_data),
        .busy            (busy),
        .fetch_count     (fetch_count)
    );

    // Program memory: either a fixed word or C0 followed by the requested address.
    assign mem_read_data = use_fixed ? fixed_data : {8'hC0, mem_read_address};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse taken between clock edges; outputs must clear at once.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_valid", 64'(mem_read_valid), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(fetch_done), 64'd0);
        check("rst_instr", fetch_instr, 64'd0);
        check("rst_addr",  64'(mem_read_address), 64'd0);
        check("rst_count", 64'(fetch_count), 64'd0);
        reset = 1'b0;
        exp_count = 0;
        for (int k = 0; k < 4; k++) exp_instr[k] = 16'h0000;
    endtask

    // One fetch starting in IDLE; waits>0 holds ready low that many cycles and
    // flips every fetch_pc during the wait to show the granted address is latched.
    task automatic fetch_one(input int t, input logic [7:0] a, input logic [15:0] d, input int waits);
        mem_read_ready = (waits == 0);
        tick();
        check("grant_valid", 64'(mem_read_valid), 64'd1);
        check("grant_addr",  64'(mem_read_address), 64'(a));
        check("grant_busy",  64'(busy), 64'd1);
        check("grant_done",  64'(fetch_done), 64'd0);
        for (int w = 0; w < waits; w++) begin
            if (w == 0) fetch_pc = ~fetch_pc;
            tick();
            check("wait_valid", 64'(mem_read_valid), 64'd1);
            check("wait_addr",  64'(mem_read_address), 64'(a));
            check("wait_done",  64'(fetch_done), 64'd0);
        end
        mem_read_ready = 1'b1;
        tick();
        exp_count    = (exp_count + 1) % 16;
        exp_instr[t] = d;
        check("done_pulse", 64'(fetch_done), 64'(1) << t);
        check("done_valid", 64'(mem_read_valid), 64'd0);
        check("done_count", 64'(fetch_count), 64'(exp_count));
        for (int k = 0; k < 4; k++)
            check("done_instr", 64'(fetch_instr[k*16 +: 16]), 64'(exp_instr[k]));
        mem_read_ready = 1'b0;
        tick();
        check("respond_done",  64'(fetch_done), 64'd0);
        check("respond_busy",  64'(busy), 64'd0);
        check("respond_valid", 64'(mem_read_valid), 64'd0);
    endtask

    initial begin
        reset          = 1'b1;
        fetch_req      = 4'b0000;
        fetch_pc       = 32'h0;
        mem_read_ready = 1'b0;
        use_fixed      = 1'b0;
        fixed_data     = 16'h0000;
        #3;
        do_reset();

        // 1: reset in the middle of a stalled REQUEST
        fetch_pc  = {8'h13, 8'h12, 8'h11, 8'h33};
        fetch_req = 4'b0001;
        tick();
        check("t1_req_valid", 64'(mem_read_valid), 64'd1);
        check("t1_req_busy",  64'(busy), 64'd1);
        check("t1_req_addr",  64'(mem_read_address), 64'h33);
        #2;
        fetch_req = 4'b0000;
        do_reset();
        mem_read_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_idle_busy",  64'(busy), 64'd0);
            check("t1_idle_valid", 64'(mem_read_valid), 64'd0);
            check("t1_idle_done",  64'(fetch_done), 64'd0);
            check("t1_idle_count", 64'(fetch_count), 64'd0);
        end
        mem_read_ready = 1'b0;

        // 2: single zero-wait fetch on thread 2
        use_fixed  = 1'b1;
        fixed_data = 16'hBEEF;
        fetch_pc   = {8'h00, 8'h1A, 8'h00, 8'h00};
        fetch_req  = 4'b0100;
        fetch_one(2, 8'h1A, 16'hBEEF, 0);
        fetch_req  = 4'b0000;
        tick();
        check("t2_stay_idle", 64'(busy), 64'd0);

        // 3: round-robin with all threads requesting continuously
        do_reset();
        use_fixed = 1'b0;
        fetch_pc  = {8'h13, 8'h12, 8'h11, 8'h10};
        fetch_req = 4'b1111;
        fetch_one(0, 8'h10, 16'hC010, 0);
        fetch_one(1, 8'h11, 16'hC011, 0);
        fetch_one(2, 8'h12, 16'hC012, 0);
        fetch_one(3, 8'h13, 16'hC013, 0);
        fetch_one(0, 8'h10, 16'hC010, 0);
        fetch_one(1, 8'h11, 16'hC011, 0);
        fetch_req = 4'b0000;

        // 4: five wait states on thread 2, PC changed while waiting
        use_fixed  = 1'b1;
        fixed_data = 16'h1234;
        fetch_pc   = {8'h13, 8'h2C, 8'h11, 8'h10};
        fetch_req  = 4'b0100;
        fetch_one(2, 8'h2C, 16'h1234, 5);
        fetch_req  = 4'b0000;

        // 5: rr_ptr is now 3; threads 1 and 3 request, 3 goes first
        use_fixed = 1'b0;
        fetch_pc  = {8'h43, 8'h00, 8'h41, 8'h00};
        fetch_req = 4'b1010;
        fetch_one(3, 8'h43, 16'hC043, 0);
        fetch_req = 4'b0010;
        fetch_one(1, 8'h41, 16'hC041, 0);
        fetch_req = 4'b0000;
        check("t5_instr0_kept", 64'(fetch_instr[15:0]),  64'hC010);
        check("t5_instr2_kept", 64'(fetch_instr[47:32]), 64'h1234);

        // 6: 17 fetches from reset wrap the 4-bit counter to 1
        do_reset();
        fetch_pc  = {8'h13, 8'h12, 8'h11, 8'h10};
        fetch_req = 4'b1111;
        for (int i = 0; i < 17; i++) begin
            logic [7:0] a;
            a = 8'h10 + 8'(i % 4);
            fetch_one(i % 4, a, {8'hC0, a}, 0);
        end
        fetch_req = 4'b0000;
        check("t6_final_count", 64'(fetch_count), 64'd1);
        tick();
        check("t6_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
